// File: rtl/sysresp_pkg.sv
// Shared types and constants for the syscall responder: FSM states,
// recognised syscall codes and the active-low 7-segment glyph table.
package sysresp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_HALTED
  } state_e;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  // Bit order {g,f,e,d,c,b,a}; a cleared bit lights the segment.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/syscall_responder_if.sv
// CPU-to-responder syscall handshake: the CPU drives a request, the
// responder answers with a same-cycle ready.
interface syscall_responder_if;
  logic        sys_valid;
  logic [31:0] sys_code;
  logic [31:0] sys_arg;
  logic        sys_ready;

  modport master (output sys_valid, sys_code, sys_arg, input sys_ready);
  modport slave  (input sys_valid, sys_code, sys_arg, output sys_ready);
endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment glyph, {g,f,e,d,c,b,a}.
module hex_to_seg7
  import sysresp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_GLYPH[nibble_i];
endmodule

// File: rtl/syscall_responder.sv
// Syscall responder: buffers PRINT_INT values, shows each for HOLD_CYCLES,
// then halts after EXIT. Define SYSRESP_SEG_EN to add the 7-segment scan driver.
module syscall_responder
  import sysresp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int SCAN_DIV    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  syscall_responder_if.slave   sys,
  output logic [31:0]          disp_value,
  output logic                 disp_valid,
  output logic                 halted
`ifdef SYSRESP_SEG_EN
  ,
  output logic [7:0]           seg_an,
  output logic [6:0]           seg_cat
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full;
  logic        accept, push, pop;
  logic [31:0] head;

  state_e      state_q;
  logic [HW-1:0] hold_q;
  logic        halt_pending_q;
  logic [31:0] disp_value_q;
  logic        disp_valid_q;
  logic        halted_q;

  // The extra pointer MSB tells a full buffer from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign sys.sys_ready = !fifo_full && !halt_pending_q && !halted_q;
  assign accept = sys.sys_valid && sys.sys_ready;
  assign push   = accept && (sys.sys_code == SYS_PRINT_INT);
  assign pop    = !fifo_empty &&
                  ((state_q == ST_IDLE) || (state_q == ST_SHOW && hold_q == '0));
  assign head   = fifo_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= sys.sys_arg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      halt_pending_q <= 1'b0;
      disp_value_q   <= '0;
      disp_valid_q   <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      if (accept && sys.sys_code == SYS_EXIT) halt_pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            disp_value_q <= head;
            hold_q       <= HOLD_LAST;
            disp_valid_q <= 1'b1;
            state_q      <= ST_SHOW;
          end else if (halt_pending_q) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end
        end
        ST_SHOW: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (pop) begin
            disp_value_q <= head;
            hold_q       <= HOLD_LAST;
          end else begin
            disp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_HALTED: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
  assign halted     = halted_q;

`ifdef SYSRESP_SEG_EN
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt_q;
  logic [2:0]    digit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
    end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      digit_q    <= digit_q + 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  assign seg_an = ~(8'h01 << digit_q);

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (disp_value_q[{digit_q, 2'b00} +: 4]),
    .seg_o    (seg_cat)
  );
`endif

endmodule

// File: tb/tb_syscall_responder.sv
// Directed self-checking bench for syscall_responder (default parameters).
module tb_syscall_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] disp_value;
  logic        disp_valid;
  logic        halted;
`ifdef SYSRESP_SEG_EN
  logic [7:0]  seg_an;
  logic [6:0]  seg_cat;
`endif

  syscall_responder_if sys_if ();

  syscall_responder #(
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (16),
    .SCAN_DIV    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys        (sys_if.slave),
    .disp_value (disp_value),
    .disp_valid (disp_valid),
    .halted     (halted)
`ifdef SYSRESP_SEG_EN
    ,
    .seg_an     (seg_an),
    .seg_cat    (seg_cat)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Display trace gathered while mon_en is set.
  bit          mon_en = 1'b0;
  int          run_len = 0;
  int          max_run = 0;
  bit          saw_stall = 1'b0;
  logic [31:0] shown [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (disp_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (shown.size() == 0 || shown[$] != disp_value) shown.push_back(disp_value);
      end else begin
        run_len = 0;
      end
      if (!sys_if.sys_ready) saw_stall = 1'b1;
    end
  endtask

  task automatic request(input logic [31:0] code, input logic [31:0] arg);
    sys_if.sys_valid = 1'b1;
    sys_if.sys_code  = code;
    sys_if.sys_arg   = arg;
  endtask

  initial begin
    int cnt;
    int guard;
    bit ready_seen;
    rst_n = 1'b0;
    sys_if.sys_valid = 1'b0;
    sys_if.sys_code  = '0;
    sys_if.sys_arg   = '0;

    // Reset state
    tick();
    tick();
    check("rst_disp_value", disp_value, 32'h0);
    check("rst_disp_valid", {31'b0, disp_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;
    check("rst_ready", {31'b0, sys_if.sys_ready}, 32'h1);

    // Print once: visible after N+1, held 16 cycles
    request(32'd1, 32'h1234);
    check("p1_ready", {31'b0, sys_if.sys_ready}, 32'h1);
    tick();
    sys_if.sys_valid = 1'b0;
    check("p1_not_yet", {31'b0, disp_valid}, 32'h0);
    tick();
    check("p1_value", disp_value, 32'h1234);
    check("p1_valid", {31'b0, disp_valid}, 32'h1);
    cnt = 1;
    for (int g = 0; g < 40 && disp_valid; g++) begin
      tick();
      if (disp_valid) cnt++;
    end
    check("p1_hold_len", cnt, 32'd16);
    check("p1_retained", disp_value, 32'h1234);

    // Back-to-back 1..5 with a depth-4 buffer
    mon_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      request(32'd1, i);
      guard = 0;
      while (!sys_if.sys_ready && guard < 50) begin
        tick();
        guard++;
      end
      tick();
    end
    sys_if.sys_valid = 1'b0;
    check("b2b_full_ready", {31'b0, sys_if.sys_ready}, 32'h0);
    guard = 0;
    while ((disp_valid || shown.size() < 5) && guard < 200) begin
      tick();
      guard++;
    end
    mon_en = 1'b0;
    check("b2b_stall_seen", {31'b0, saw_stall}, 32'h1);
    check("b2b_count", shown.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("b2b_order%0d", i), (i < shown.size()) ? shown[i] : 32'hX, i + 1);
    check("b2b_no_gap", max_run, 32'd80);

    // Exit ordering: 7, EXIT, then 9 stalls forever
    request(32'd1, 32'd7);
    tick();
    request(32'd10, 32'd0);
    check("exit_accept", {31'b0, sys_if.sys_ready}, 32'h1);
    tick();
    request(32'd1, 32'd9);
    check("exit_stall", {31'b0, sys_if.sys_ready}, 32'h0);
    check("exit_show7", disp_value, 32'd7);
    cnt = 1;
    ready_seen = 1'b0;
    for (int g = 0; g < 40 && disp_valid; g++) begin
      tick();
      if (disp_valid) cnt++;
      if (sys_if.sys_ready) ready_seen = 1'b1;
    end
    check("exit_hold_len", cnt, 32'd16);
    check("exit_halt_late", {31'b0, halted}, 32'h0);
    tick();
    check("exit_halted", {31'b0, halted}, 32'h1);
    for (int g = 0; g < 5; g++) begin
      tick();
      if (sys_if.sys_ready) ready_seen = 1'b1;
    end
    check("exit_never_ready", {31'b0, ready_seen}, 32'h0);
    check("exit_no9", disp_value, 32'd7);
    check("exit_valid_low", {31'b0, disp_valid}, 32'h0);
    check("exit_sticky", {31'b0, halted}, 32'h1);
    sys_if.sys_valid = 1'b0;

    // Reset out of HALTED, then an unknown code
    rst_n = 1'b0;
    tick();
    check("rh_halted", {31'b0, halted}, 32'h0);
    check("rh_value", disp_value, 32'h0);
    rst_n = 1'b1;
    check("rh_ready", {31'b0, sys_if.sys_ready}, 32'h1);
    request(32'd5, 32'hDEAD);
    check("unk_ready", {31'b0, sys_if.sys_ready}, 32'h1);
    tick();
    sys_if.sys_valid = 1'b0;
    check("unk_ready_after", {31'b0, sys_if.sys_ready}, 32'h1);
    cnt = 0;
    for (int g = 0; g < 4; g++) begin
      tick();
      if (disp_valid) cnt++;
    end
    check("unk_no_show", cnt, 32'd0);
    request(32'd1, 32'h55);
    tick();
    sys_if.sys_valid = 1'b0;
    tick();
    check("unk_fifo_clean", disp_value, 32'h55);

    // Reset mid-SHOW with two values queued
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    request(32'd1, 32'hA);
    tick();
    request(32'd1, 32'hB);
    tick();
    request(32'd1, 32'hC);
    tick();
    sys_if.sys_valid = 1'b0;
    check("mid_show_a", disp_value, 32'hA);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_value", disp_value, 32'h0);
    check("mid_rst_valid", {31'b0, disp_valid}, 32'h0);
    check("mid_rst_halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;
    check("mid_rst_ready", {31'b0, sys_if.sys_ready}, 32'h1);
    cnt = 0;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (disp_valid) cnt++;
    end
    check("mid_discarded", cnt, 32'd0);

`ifdef SYSRESP_SEG_EN
    begin
      logic [6:0]  glyph [16];
      logic [31:0] pat;
      int          d;
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      pat = 32'h89ABCDEF;
      rst_n = 1'b0;
      tick();
      check("scan_rst_an", {24'b0, seg_an}, 32'hFE);
      rst_n = 1'b1;
      request(32'd1, pat);
      tick();
      sys_if.sys_valid = 1'b0;
      tick();
      check("scan_d0_glyph", {25'b0, seg_cat}, 32'h0E);
      for (int k = 2; k <= 33; k++) begin
        d = (k / 4) % 8;
        check($sformatf("scan_an_k%0d", k), {24'b0, seg_an}, {24'b0, ~(8'h01 << d)});
        check($sformatf("scan_cat_k%0d", k), {25'b0, seg_cat}, {25'b0, glyph[(pat >> (4 * d)) & 32'hF]});
        tick();
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syscall_responder.md
SYSCALL_RESPONDER -- requirements
Module: syscall_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, print-value buffer depth; SHALL be a power of two, at least 2.
REQ-002 Parameter HOLD_CYCLES, default 16, cycles each value stays on display; SHALL be at least 1.
REQ-003 Parameter SCAN_DIV, default 4, cycles per 7-segment digit slot.
REQ-004 clk  in  1  single clock, rising-edge active.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 sys_valid  in  1  CPU syscall request this cycle.
REQ-007 sys_code  in  32  syscall code (CPU register $2).
REQ-008 sys_arg  in  32  syscall argument (CPU register $4).
REQ-009 sys_ready  out  1  request accepted this cycle; CPU SHALL hold PC while sys_valid && !sys_ready.
REQ-010 disp_value  out  32  value currently displayed.
REQ-011 disp_valid  out  1  high while a value is being held.
REQ-012 halted  out  1  sticky; CPU SHALL stop fetching when it is high.
REQ-013 seg_an  out  8  digit enables, one-hot, active-low (SYSRESP_SEG_EN only).
REQ-014 seg_cat  out  7  segments a..g, active-low (SYSRESP_SEG_EN only).

Function
REQ-015 Accept SHALL be sys_valid && sys_ready; sys_ready SHALL equal !fifo_full && !halt_pending && !halted (combinational).
REQ-016 Accepted code 1 (PRINT_INT) SHALL push sys_arg; code 10 (EXIT) SHALL set halt_pending; any other code SHALL be accepted and ignored.
REQ-017 The FIFO SHALL be circular; pointers SHALL wrap at FIFO_DEPTH. Full and empty SHALL be distinguished by an extra pointer bit.
REQ-018 A push is not allowed while the FIFO is full, even if a pop occurs in the same cycle. Push and pop in the same cycle while not full SHALL both take effect.
REQ-019 The FSM SHALL have three states: IDLE, SHOW and HALTED.
REQ-020 IDLE, FIFO non-empty: pop; disp_value <= head; hold counter <= HOLD_CYCLES-1; go to SHOW.
REQ-021 IDLE, FIFO empty and halt_pending: go to HALTED.
REQ-022 SHOW: the counter SHALL decrement each cycle. At 0: pop the next value if the FIFO is non-empty (stay in SHOW, reload the counter); otherwise go to IDLE.
REQ-023 disp_valid SHALL be 1 exactly in SHOW. disp_value SHALL retain its last value in IDLE and HALTED.
REQ-024 Latency: a value accepted at edge N with the FIFO empty and the FSM in IDLE SHALL appear on disp_value after edge N+1. It SHALL be held for HOLD_CYCLES cycles.
REQ-025 halted SHALL be 1 exactly in HALTED. HALTED SHALL be left only by reset. Every value pushed before EXIT SHALL be shown before halted rises.

Reset
REQ-026 When rst_n=0 at an edge: FSM to IDLE; FIFO empty; halt_pending=0; disp_value=0; disp_valid=0; halted=0; hold and scan counters=0; seg_an=8'hFE.
REQ-027 Reset mid-SHOW or in HALTED SHALL discard all buffered values. sys_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-028 With SYSRESP_SEG_EN defined, the block SHALL include the scan driver. Every SCAN_DIV cycles the digit index advances 0..7 and wraps. seg_an bit i is low for the active digit i. seg_cat is the hex glyph of disp_value[4i+3:4i].
REQ-029 Without SYSRESP_SEG_EN, seg_an and seg_cat SHALL be absent and there SHALL be no scan logic. All other behaviour SHALL be identical.

Structure
REQ-030 Package sysresp_pkg SHALL hold: the FSM state enum; SYS_PRINT_INT=1 and SYS_EXIT=10; the 16-entry active-low glyph table.
REQ-031 Sub-module hex_to_seg7 (4-bit in, 7-bit out) SHALL be instantiated only under SYSRESP_SEG_EN.

Verification
REQ-032 Print once: after reset, a PRINT_INT request with arg 32'h1234 -> disp_value=32'h1234 after edge N+1; disp_valid high for exactly 16 cycles, then IDLE.
REQ-033 Back-to-back and full: 5 PRINT_INT requests (args 1..5) on consecutive cycles with FIFO_DEPTH=4 -> sys_ready low at least once. Values shown in order 1,2,3,4,5 with no gap between holds.
REQ-034 Exit ordering: PRINT_INT 7, then EXIT, then PRINT_INT 9 -> 7 is shown. The request with arg 9 stalls (sys_ready=0). halted rises one cycle after the hold of 7 ends; 9 is never shown.
REQ-035 Unknown code: code 5 with arg 32'hDEAD -> accepted in one cycle, FIFO unchanged, disp_valid stays 0.
REQ-036 Reset mid-operation: rst_n=0 during the SHOW of 32'hA, with 2 values queued -> after reset all outputs at reset values. The queued values are never shown.
REQ-037 Scan (SYSRESP_SEG_EN): disp_value=32'h89ABCDEF, SCAN_DIV=4 -> seg_an cycles FE,FD,..,7F every 4 cycles. On digit 0, seg_cat is the glyph for F.
